// File: rtl/getir_pkg.sv
// Shared definitions for the fetch stage: parcel width, aligner state codes,
// the RVC-detect constant and the aligned output record.
package getir_pkg;
    localparam int PARSEL_BIT = 16;

    localparam logic [0:0] HZ_NORMAL = 1'b0;
    localparam logic [0:0] HZ_DUSUR  = 1'b1;

    localparam logic [1:0] RVC_YOK = 2'b11;

    typedef struct packed {
        logic [31:0] buyruk;
        logic [31:0] ps;
        logic        rvc;
    } cikis_t;

    function automatic logic rvc_mi(input logic [PARSEL_BIT-1:0] parsel);
        return (parsel[1:0] != RVC_YOK);
    endfunction
endpackage

// File: rtl/buyruk_hizalayici_if.sv
// Handshake bundle tying fetch stage 1, the L1 instruction cache response
// port and decode to the instruction aligner.
interface buyruk_hizalayici_if #(parameter int OBEK_BIT = 32);
    logic                g1_istek_yapildi_i;
    logic                g1_istek_izin_o;
    logic [OBEK_BIT-1:0] l1b_obek_i;
    logic [31:0]         l1b_obek_ps_i;
    logic                l1b_obek_gecerli_i;
    logic                l1b_obek_hazir_o;
    logic [31:0]         coz_buyruk_o;
    logic [31:0]         coz_buyruk_ps_o;
    logic                coz_buyruk_rvc_o;
    logic                coz_buyruk_gecerli_o;
    logic                coz_buyruk_hazir_i;
    logic                bosalt_i;

    modport slave (
        input  g1_istek_yapildi_i, l1b_obek_i, l1b_obek_ps_i, l1b_obek_gecerli_i,
               coz_buyruk_hazir_i, bosalt_i,
        output g1_istek_izin_o, l1b_obek_hazir_o, coz_buyruk_o, coz_buyruk_ps_o,
               coz_buyruk_rvc_o, coz_buyruk_gecerli_o
    );

    modport master (
        output g1_istek_yapildi_i, l1b_obek_i, l1b_obek_ps_i, l1b_obek_gecerli_i,
               coz_buyruk_hazir_i, bosalt_i,
        input  g1_istek_izin_o, l1b_obek_hazir_o, coz_buyruk_o, coz_buyruk_ps_o,
               coz_buyruk_rvc_o, coz_buyruk_gecerli_o
    );
endinterface

// File: rtl/buyruk_hizalayici_parsel_kuyrugu.sv
// Circular 16-bit parcel queue: writes a variable run of parcels from one
// fetch block, exposes the two head parcels and pops 0, 1 or 2 per cycle.
module parsel_kuyrugu
    import getir_pkg::*;
#(
    parameter  int OBEK_BIT        = 32,
    parameter  int KUYRUK_DERINLIK = 8,
    localparam int P  = OBEK_BIT / PARSEL_BIT,
    localparam int OW = $clog2(P),
    localparam int CW = $clog2(P + 1),
    localparam int AW = $clog2(KUYRUK_DERINLIK)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  temizle_i,
    input  logic                  yaz_i,
    input  logic [OBEK_BIT-1:0]   yaz_obek_i,
    input  logic [OW-1:0]         yaz_ofset_i,
    input  logic [CW-1:0]         yaz_sayi_i,
    input  logic [1:0]            cek_sayi_i,
    output logic [PARSEL_BIT-1:0] bas0_o,
    output logic [PARSEL_BIT-1:0] bas1_o,
    output logic [AW:0]           dolu_o
);
    logic [PARSEL_BIT-1:0] r_bellek [KUYRUK_DERINLIK];
    logic [AW-1:0]         r_oku;
    logic [AW-1:0]         r_yaz;
    logic [AW:0]           r_dolu;
    logic [OBEK_BIT-1:0]   w_kaydirilmis;
    logic [CW-1:0]         w_eklenen;

    // Leading parcels before the start offset are shifted out so the kept run starts at bit 0.
    assign w_kaydirilmis = yaz_obek_i >> {yaz_ofset_i, 4'b0000};
    assign w_eklenen     = yaz_i ? yaz_sayi_i : {CW{1'b0}};

    // Parcel storage write port.
    always_ff @(posedge clk_i) begin
        if (yaz_i && !temizle_i) begin
            for (int i = 0; i < P; i++) begin
                if (CW'(i) < yaz_sayi_i) begin
                    r_bellek[r_yaz + AW'(i)] <= w_kaydirilmis[i*PARSEL_BIT +: PARSEL_BIT];
                end
            end
        end
    end

    // Pointer and occupancy bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i || temizle_i) begin
            r_oku  <= {AW{1'b0}};
            r_yaz  <= {AW{1'b0}};
            r_dolu <= {(AW+1){1'b0}};
        end else begin
            r_yaz  <= r_yaz + AW'(w_eklenen);
            r_oku  <= r_oku + AW'(cek_sayi_i);
            r_dolu <= r_dolu + (AW+1)'(w_eklenen) - (AW+1)'(cek_sayi_i);
        end
    end

    assign bas0_o = r_bellek[r_oku];
    assign bas1_o = r_bellek[r_oku + AW'(1)];
    assign dolu_o = r_dolu;
endmodule

// File: rtl/buyruk_hizalayici.sv
// Fetch-stage-2 aligner: turns cache blocks into one aligned instruction per
// cycle and drops stale responses after a flush. RVC support: HIZALAYICI_RVC_EN.
module buyruk_hizalayici
    import getir_pkg::*;
#(
    parameter int OBEK_BIT        = 32,
    parameter int KUYRUK_DERINLIK = 8,
    parameter int MAKS_BEKLEYEN   = 4
) (
    input logic               clk_i,
    input logic               rst_i,
    buyruk_hizalayici_if.slave bh
);
    localparam int P  = OBEK_BIT / PARSEL_BIT;
    localparam int OW = $clog2(P);
    localparam int CW = $clog2(P + 1);
    localparam int AW = $clog2(KUYRUK_DERINLIK);
    localparam int BW = $clog2(MAKS_BEKLEYEN + 1);
    localparam logic [AW:0] KD_W = (AW+1)'(KUYRUK_DERINLIK);
`ifdef HIZALAYICI_RVC_EN
    localparam bit RVC_EN = 1'b1;
`else
    localparam bit RVC_EN = 1'b0;
`endif

    logic [0:0]      r_durum;
    logic            r_ilk, r_aktif, r_izin, r_gecerli;
    logic [BW-1:0]   r_bekleyen, r_dusur;
    logic [31:0]     r_bas_ps;
    cikis_t          r_cikis;

    logic [OW-1:0]   w_ofset_ham, w_ofset;
    logic [CW-1:0]   w_yaz_sayi;
    logic [AW:0]     w_dolu, w_bos;
    logic [15:0]     w_bas0, w_bas1;
    logic            w_hazir, w_kabul, w_yaz, w_bas_rvc, w_mevcut, w_yukle;
    logic [1:0]      w_cek;
    logic [BW-1:0]   w_bekleyen_ns, w_dusur_ns;

    // Without RVC every instruction starts on an even parcel.
    assign w_ofset_ham = bh.l1b_obek_ps_i[OW:1];
    assign w_ofset     = !r_ilk ? {OW{1'b0}} : (RVC_EN ? w_ofset_ham : (w_ofset_ham & ~OW'(1)));
    assign w_yaz_sayi  = CW'(P) - CW'(w_ofset);
    assign w_bos       = KD_W - w_dolu;
    assign w_hazir     = r_aktif && ((r_durum == HZ_DUSUR) || (w_bos >= (AW+1)'(w_yaz_sayi)));
    assign w_kabul     = bh.l1b_obek_gecerli_i && w_hazir;
    assign w_yaz       = w_kabul && !bh.bosalt_i && (r_durum == HZ_NORMAL);

    assign w_bas_rvc   = RVC_EN && rvc_mi(w_bas0);
    assign w_mevcut    = w_bas_rvc ? (w_dolu != '0) : (w_dolu >= (AW+1)'(2));
    assign w_yukle     = w_mevcut && (!r_gecerli || bh.coz_buyruk_hazir_i) && !bh.bosalt_i;
    assign w_cek       = !w_yukle ? 2'd0 : (w_bas_rvc ? 2'd1 : 2'd2);

    assign w_bekleyen_ns = r_bekleyen + BW'(bh.g1_istek_yapildi_i) - BW'(w_kabul);
    assign w_dusur_ns    = r_bekleyen - BW'(w_kabul);

    parsel_kuyrugu #(.OBEK_BIT(OBEK_BIT), .KUYRUK_DERINLIK(KUYRUK_DERINLIK)) u_kuyruk (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .temizle_i  (bh.bosalt_i),
        .yaz_i      (w_yaz),
        .yaz_obek_i (bh.l1b_obek_i),
        .yaz_ofset_i(w_ofset),
        .yaz_sayi_i (w_yaz_sayi),
        .cek_sayi_i (w_cek),
        .bas0_o     (w_bas0),
        .bas1_o     (w_bas1),
        .dolu_o     (w_dolu)
    );

    // Request accounting, stale-response draining and head PC tracking.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_durum    <= HZ_NORMAL;
            r_ilk      <= 1'b1;
            r_aktif    <= 1'b0;
            r_izin     <= 1'b0;
            r_bekleyen <= {BW{1'b0}};
            r_dusur    <= {BW{1'b0}};
            r_bas_ps   <= 32'h0000_0000;
        end else begin
            r_aktif    <= 1'b1;
            r_bekleyen <= w_bekleyen_ns;
            r_izin     <= (w_bekleyen_ns < BW'(MAKS_BEKLEYEN));
            if (bh.bosalt_i) begin
                r_ilk   <= 1'b1;
                r_dusur <= w_dusur_ns;
                r_durum <= (w_dusur_ns != '0) ? HZ_DUSUR : HZ_NORMAL;
            end else if (r_durum == HZ_DUSUR) begin
                if (w_kabul) begin
                    r_dusur <= r_dusur - BW'(1);
                    if (r_dusur == BW'(1)) begin
                        r_durum <= HZ_NORMAL;
                    end
                end
            end else if (w_yaz && r_ilk) begin
                r_bas_ps <= bh.l1b_obek_ps_i;
                r_ilk    <= 1'b0;
            end else if (w_cek != 2'd0) begin
                r_bas_ps <= r_bas_ps + (w_bas_rvc ? 32'd2 : 32'd4);
            end
        end
    end

    // Output register: holds while decode stalls, cleared by flush.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_cikis   <= '0;
            r_gecerli <= 1'b0;
        end else if (bh.bosalt_i) begin
            r_gecerli <= 1'b0;
        end else if (w_yukle) begin
            r_cikis.buyruk <= w_bas_rvc ? {16'h0000, w_bas0} : {w_bas1, w_bas0};
            r_cikis.ps     <= r_bas_ps;
            r_cikis.rvc    <= w_bas_rvc;
            r_gecerli      <= 1'b1;
        end else if (bh.coz_buyruk_hazir_i) begin
            r_gecerli <= 1'b0;
        end
    end

    assign bh.g1_istek_izin_o      = r_izin;
    assign bh.l1b_obek_hazir_o     = w_hazir;
    assign bh.coz_buyruk_o         = r_cikis.buyruk;
    assign bh.coz_buyruk_ps_o      = r_cikis.ps;
    assign bh.coz_buyruk_rvc_o     = r_cikis.rvc;
    assign bh.coz_buyruk_gecerli_o = r_gecerli;
endmodule

// File: tb/tb_buyruk_hizalayici.sv
// Randomised scoreboard bench for buyruk_hizalayici: a cache model with
// flush epochs feeds blocks, a parcel-stream reference predicts instructions.
module tb_buyruk_hizalayici;
    localparam int OBEK_BIT = 64;
    localparam int KD       = 8;
    localparam int MAKS     = 4;
    localparam int P        = OBEK_BIT / 16;
    localparam int BAYT     = OBEK_BIT / 8;
    localparam int DONGU    = 3000;
`ifdef HIZALAYICI_RVC_EN
    localparam bit RVC = 1'b1;
`else
    localparam bit RVC = 1'b0;
`endif

    typedef struct {
        logic [31:0] buyruk;
        logic [31:0] ps;
        logic        rvc;
    } beklenen_t;

    typedef struct {
        logic [OBEK_BIT-1:0] veri;
        logic [31:0]         ps;
        int                  donem;
    } yanit_t;

    logic clk;
    logic rst;
    buyruk_hizalayici_if #(.OBEK_BIT(OBEK_BIT)) bh ();

    buyruk_hizalayici #(
        .OBEK_BIT(OBEK_BIT), .KUYRUK_DERINLIK(KD), .MAKS_BEKLEYEN(MAKS)
    ) dut (
        .clk_i(clk),
        .rst_i(rst),
        .bh   (bh)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    beklenen_t   sb[$];
    yanit_t      istekler[$];
    logic [15:0] parseller[$];
    logic [31:0] model_ps;
    logic [31:0] sonraki_ps;
    int          donem;
    bit          donem_basladi;
    int          n_check;
    int          n_fail;
    int          cyc;
    int          cyc_kabul;
    int          n_istek;

    task automatic kontrol(input string ad, input logic [63:0] gercek, input logic [63:0] beklenen);
        n_check++;
        if (gercek !== beklenen) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", ad, gercek, beklenen, cyc);
        end
    endtask

    function automatic int ofset(input logic [31:0] ps);
        int o;
        o = int'((ps >> 1) % P);
        if (!RVC) o = o & ~1;
        return o;
    endfunction

    // Turn the pending parcel stream into complete instructions, in program order.
    function automatic void genislet();
        logic [15:0] h;
        beklenen_t   e;
        while (parseller.size() > 0) begin
            h = parseller[0];
            if (RVC && h[1:0] != 2'b11) begin
                e.buyruk = {16'h0000, h}; e.ps = model_ps; e.rvc = 1'b1;
                sb.push_back(e);
                void'(parseller.pop_front());
                model_ps += 32'd2;
            end else if (parseller.size() >= 2) begin
                e.buyruk = {parseller[1], h}; e.ps = model_ps; e.rvc = 1'b0;
                sb.push_back(e);
                void'(parseller.pop_front());
                void'(parseller.pop_front());
                model_ps += 32'd4;
            end else begin
                break;
            end
        end
    endfunction

    // Parcels held by the aligner queue: everything accepted minus the instruction sitting in the output.
    function automatic int doluluk();
        int n;
        n = parseller.size();
        foreach (sb[i]) n += sb[i].rvc ? 1 : 2;
        if (bh.coz_buyruk_gecerli_o && sb.size() > 0) n -= sb[0].rvc ? 1 : 2;
        return n;
    endfunction

    function automatic bit bayat_var();
        foreach (istekler[i]) if (istekler[i].donem != donem) return 1'b1;
        return 1'b0;
    endfunction

    // Driver, cache model and reference model.
    initial begin : surucu
        bit     tut;
        bit     kabul;
        bit     bp;
        logic   hazir_bek;
        yanit_t r;
        int     o;
        n_check = 0; n_fail = 0; cyc = 0; cyc_kabul = -1; n_istek = 0;
        donem = 0; donem_basladi = 1'b0; sonraki_ps = 32'h0000_1000; model_ps = 32'h0;
        tut = 1'b0;
        rst = 1'b1;
        bh.g1_istek_yapildi_i = 1'b0; bh.l1b_obek_i = '0; bh.l1b_obek_ps_i = 32'h0;
        bh.l1b_obek_gecerli_i = 1'b0; bh.coz_buyruk_hazir_i = 1'b0; bh.bosalt_i = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        kontrol("rst_izin",    bh.g1_istek_izin_o,      64'd0);
        kontrol("rst_hazir",   bh.l1b_obek_hazir_o,     64'd0);
        kontrol("rst_gecerli", bh.coz_buyruk_gecerli_o, 64'd0);
        kontrol("rst_buyruk",  bh.coz_buyruk_o,         64'd0);
        kontrol("rst_ps",      bh.coz_buyruk_ps_o,      64'd0);
        kontrol("rst_rvc",     bh.coz_buyruk_rvc_o,     64'd0);
        rst = 1'b0;
        #1;
        kontrol("izin_gecikmeli", bh.g1_istek_izin_o, 64'd0);

        for (int c = 0; c < DONGU; c++) begin
            @(negedge clk);
            cyc++;
            bp = (cyc >= 1200 && cyc < 1260);
            bh.bosalt_i = (cyc > 20) && !bp && ($urandom_range(0, 39) == 0);
            bh.coz_buyruk_hazir_i = bp ? 1'b0 : ($urandom_range(0, 3) != 0);
            bh.l1b_obek_gecerli_i = (istekler.size() > 0) && (tut || ($urandom_range(0, 3) != 0));
            bh.l1b_obek_i    = (istekler.size() > 0) ? istekler[0].veri : '0;
            bh.l1b_obek_ps_i = (istekler.size() > 0) ? istekler[0].ps : 32'h0;
            bh.g1_istek_yapildi_i = bh.g1_istek_izin_o && ($urandom_range(0, 2) != 0);
            #2;
            kontrol("g1_izin", bh.g1_istek_izin_o, (istekler.size() < MAKS) ? 64'd1 : 64'd0);
            o = donem_basladi ? 0 : ofset(bh.l1b_obek_ps_i);
            hazir_bek = bayat_var() ? 1'b1 : ((KD - doluluk()) >= (P - o));
            kontrol("l1b_hazir", bh.l1b_obek_hazir_o, hazir_bek);
            #2;
            kabul = bh.l1b_obek_gecerli_i && bh.l1b_obek_hazir_o;
            tut = bh.l1b_obek_gecerli_i && !kabul;
            if (kabul) begin
                r = istekler.pop_front();
                if (!bh.bosalt_i && r.donem == donem) begin
                    if (cyc_kabul < 0) cyc_kabul = cyc;
                    o = 0;
                    if (!donem_basladi) begin
                        o = ofset(r.ps);
                        model_ps = r.ps;
                        donem_basladi = 1'b1;
                    end
                    for (int i = o; i < P; i++) parseller.push_back(r.veri[i*16 +: 16]);
                    genislet();
                end
            end
            if (bh.bosalt_i) begin
                donem++;
                parseller.delete();
                sb.delete();
                donem_basladi = 1'b0;
                sonraki_ps = RVC ? (32'h3000 + 32'($urandom_range(0, 255)) * 32'd2)
                                 : (32'h3000 + 32'($urandom_range(0, 127)) * 32'd4);
            end
            if (bh.g1_istek_yapildi_i) begin
                r.ps    = sonraki_ps;
                r.donem = donem;
                r.veri  = {$urandom, $urandom};
                if (n_istek == 0) r.veri = 64'h0010_0113_00A0_0093;
                if (n_istek == 1) r.veri[31:0] = 32'h0001_4501;
                n_istek++;
                istekler.push_back(r);
                sonraki_ps = (sonraki_ps & ~32'(BAYT - 1)) + 32'(BAYT);
            end
        end
        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_check, n_fail);
        $finish;
    end

    // Monitor: pops the scoreboard on every output handshake.
    initial begin : izleyici
        logic        o_gec, o_haz, o_bos, ilk_goruldu;
        logic [31:0] o_b, o_ps;
        beklenen_t   e;
        o_gec = 1'b0; o_haz = 1'b0; o_bos = 1'b0; ilk_goruldu = 1'b0;
        o_b = 32'h0; o_ps = 32'h0;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                if (o_gec && !o_haz && !o_bos) begin
                    kontrol("sabit_gecerli", bh.coz_buyruk_gecerli_o, 64'd1);
                    kontrol("sabit_buyruk",  bh.coz_buyruk_o,  o_b);
                    kontrol("sabit_ps",      bh.coz_buyruk_ps_o, o_ps);
                end
                if (bh.coz_buyruk_gecerli_o && !ilk_goruldu) begin
                    ilk_goruldu = 1'b1;
                    kontrol("ilk_gecikme", 64'(cyc), 64'(cyc_kabul + 2));
                end
                if (bh.coz_buyruk_gecerli_o && bh.coz_buyruk_hazir_i) begin
                    if (sb.size() == 0) begin
                        n_check++;
                        n_fail++;
                        $display("FAIL beklenmeyen_cikis: got %0h at ps %0h expected nothing (cycle %0d)",
                                 bh.coz_buyruk_o, bh.coz_buyruk_ps_o, cyc);
                    end else begin
                        e = sb.pop_front();
                        kontrol("buyruk", bh.coz_buyruk_o,     e.buyruk);
                        kontrol("ps",     bh.coz_buyruk_ps_o,  e.ps);
                        kontrol("rvc",    bh.coz_buyruk_rvc_o, e.rvc);
                    end
                end
                o_gec = bh.coz_buyruk_gecerli_o;
                o_haz = bh.coz_buyruk_hazir_i;
                o_bos = bh.bosalt_i;
                o_b   = bh.coz_buyruk_o;
                o_ps  = bh.coz_buyruk_ps_o;
            end
        end
    end
endmodule
